lvds_rx_frame_parser: RTL and testbench

- Upstream stage of the uplink data selector (sx_data_v4).
- Hunts for sync, parses the frame header, and streams the payload bytes out as yw_data.
- Produces info_start_flag, info_type, channel_mang and the byte_cnt_equal_25 strobe the selector uses for its frame statistics.
- Checks the trailing checksum and keeps frame and error counters.

---
 rtl/lvds_rx_pkg.sv | 33 +++
 rtl/rx_stat_counter.sv | 31 +++
 rtl/lvds_rx_frame_parser.sv | 197 +++++++++++++++++++
 tb/tb_lvds_rx_frame_parser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS uplink frame parser.
package lvds_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_TYPE,
    ST_CH_H,
    ST_CH_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CHK
  } rx_state_e;

  localparam logic [15:0] SYNC_WORD = 16'hEB90;
  localparam logic [7:0]  SYNC_H    = SYNC_WORD[15:8];
  localparam logic [7:0]  SYNC_L    = SYNC_WORD[7:0];
  localparam logic [15:0] MAX_LEN   = 16'd2048;
  localparam logic [15:0] CNT_IDX   = 16'd25;

  // Frame byte index of each header field; TYPE is index 1.
  localparam logic [15:0] OFS_TYPE  = 16'd1;
  localparam logic [15:0] OFS_CH_H  = 16'd2;
  localparam logic [15:0] OFS_CH_L  = 16'd3;
  localparam logic [15:0] OFS_LEN_H = 16'd4;
  localparam logic [15:0] OFS_LEN_L = 16'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_stat_counter.sv
// Saturating 32-bit event counter; a synchronous clear beats a same-cycle increment.
module rx_stat_counter (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lvds_rx_frame_parser.sv
// Sync hunt, header parse, payload streaming and checksum check for the LVDS uplink.
// Define RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
//   ST_IDLE    | hunting for SYNC_H
//   ST_SYNC1   | SYNC_H seen, expecting SYNC_L
//   ST_TYPE .. ST_LEN_L | header bytes
//   ST_PAYLOAD | streaming LEN bytes to yw_data
//   ST_CHK     | waiting for the checksum byte
module lvds_rx_frame_parser
  import lvds_rx_pkg::*;
(
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  i_MC_StatCLR,
  output logic        info_start_flag_o,
  output logic [7:0]  info_type_o,
  output logic [15:0] channel_mang_o,
  output logic [15:0] info_len_o,
  output logic [7:0]  yw_data_o,
  output logic        yw_data_valid_o,
  output logic        byte_cnt_equal_25_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] err_cnt_o
);

  rx_state_e   state_q, state_d;
  logic [7:0]  ch_h_q, len_h_q, info_type_q, sum_q, yw_data_q;
  logic [15:0] channel_q, info_len_q, pay_cnt_q, idx_q, len_word;
  logic        start_q, cnt25_q, done_q, err_q, yw_valid_q, clr_q;
  logic        start_d, done_d, err_d, yw_valid_d, in_frame, tmo;
  logic        unused_statclr;

  assign unused_statclr = ^i_MC_StatCLR[7:1];
  assign len_word       = {len_h_q, rx_data_i};

`ifdef RX_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYC = 32'd16384;
  logic [31:0] idle_cnt_q;

  assign tmo = (state_q != ST_IDLE) && !rx_valid_i && (idle_cnt_q == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) || rx_valid_i || tmo) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = ST_IDLE;
    end else if (rx_valid_i) begin
      case (state_q)
        ST_IDLE:  if (rx_data_i == SYNC_H) state_d = ST_SYNC1;
        ST_SYNC1: begin
          if (rx_data_i == SYNC_L)      state_d = ST_TYPE;
          else if (rx_data_i != SYNC_H) state_d = ST_IDLE;
        end
        ST_TYPE:  state_d = ST_CH_H;
        ST_CH_H:  state_d = ST_CH_L;
        ST_CH_L:  state_d = ST_LEN_H;
        ST_LEN_H: state_d = ST_LEN_L;
        ST_LEN_L: begin
          if (len_word == 16'd0)       state_d = ST_CHK;
          else if (len_word > MAX_LEN) state_d = ST_IDLE;
          else                         state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: if (pay_cnt_q + 16'd1 == info_len_q) state_d = ST_CHK;
        ST_CHK:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = tmo;
    yw_valid_d = 1'b0;
    in_frame   = 1'b0;
    if (rx_valid_i) begin
      case (state_q)
        ST_SYNC1: start_d = (rx_data_i == SYNC_L);
        ST_TYPE, ST_CH_H, ST_CH_L, ST_LEN_H: in_frame = 1'b1;
        ST_LEN_L: begin
          in_frame = 1'b1;
          err_d    = (len_word > MAX_LEN);
        end
        ST_PAYLOAD: begin
          in_frame   = 1'b1;
          yw_valid_d = 1'b1;
        end
        ST_CHK: begin
          in_frame = 1'b1;
          done_d   = (rx_data_i == sum_q);
          err_d    = (rx_data_i != sum_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      yw_valid_q  <= 1'b0;
      cnt25_q     <= 1'b0;
      clr_q       <= 1'b0;
      yw_data_q   <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      info_type_q <= '0;
      ch_h_q      <= '0;
      channel_q   <= '0;
      len_h_q     <= '0;
      info_len_q  <= '0;
      pay_cnt_q   <= '0;
    end else begin
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      yw_valid_q <= yw_valid_d;
      cnt25_q    <= in_frame && (sat_inc16(idx_q) == CNT_IDX);
      clr_q      <= i_MC_StatCLR[0];
      if (yw_valid_d) yw_data_q <= rx_data_i;
      // Index and checksum restart on SYNC_L so TYPE becomes index 1 / first addend.
      if (start_d) begin
        idx_q <= '0;
        sum_q <= '0;
      end else if (in_frame) begin
        idx_q <= sat_inc16(idx_q);
        if (state_q != ST_CHK) sum_q <= sum_q + rx_data_i;
      end
      if (rx_valid_i) begin
        case (state_q)
          ST_TYPE:  info_type_q <= rx_data_i;
          ST_CH_H:  ch_h_q      <= rx_data_i;
          ST_CH_L:  channel_q   <= {ch_h_q, rx_data_i};
          ST_LEN_H: len_h_q     <= rx_data_i;
          ST_LEN_L: begin
            info_len_q <= len_word;
            pay_cnt_q  <= '0;
          end
          ST_PAYLOAD: pay_cnt_q <= pay_cnt_q + 16'd1;
          default: ;
        endcase
      end
    end
  end

  rx_stat_counter u_frame_cnt (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (clr_q),
    .inc_i     (done_q),
    .cnt_o     (frame_cnt_o)
  );

  rx_stat_counter u_err_cnt (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (clr_q),
    .inc_i     (err_q),
    .cnt_o     (err_cnt_o)
  );

  assign info_start_flag_o   = start_q;
  assign info_type_o         = info_type_q;
  assign channel_mang_o      = channel_q;
  assign info_len_o          = info_len_q;
  assign yw_data_o           = yw_data_q;
  assign yw_data_valid_o     = yw_valid_q;
  assign byte_cnt_equal_25_o = cnt25_q;
  assign frame_done_o        = done_q;
  assign frame_err_o         = err_q;

endmodule

// File: tb/tb_lvds_rx_frame_parser.sv
// Directed bench for lvds_rx_frame_parser; honours RX_TIMEOUT_EN like the design.
module tb_lvds_rx_frame_parser;
  import lvds_rx_pkg::*;

  localparam logic [4:0] F_PL = 5'd1, F_ST = 5'd2, F_DN = 5'd4, F_ER = 5'd8, F_25 = 5'd16;
  localparam int TMO_CYC = 16384;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  i_MC_StatCLR = '0;
  logic        info_start_flag_o, yw_data_valid_o, byte_cnt_equal_25_o, frame_done_o, frame_err_o;
  logic [7:0]  info_type_o, yw_data_o;
  logic [15:0] channel_mang_o, info_len_o;
  logic [31:0] frame_cnt_o, err_cnt_o;

  logic exp_pl = 0, exp_st = 0, exp_dn = 0, exp_er = 0, exp_25 = 0;
  bit   tmo_mode = 0;
  int   n_chk = 0, n_fail = 0;
  int   n_start = 0, n_yw = 0, n_25 = 0, n_done = 0, n_err = 0;
  int   s_start, s_yw, s_25, s_done, s_err;

  lvds_rx_frame_parser dut (
    .sys_clk_i           (sys_clk_i),
    .rst_n_i             (rst_n_i),
    .rx_data_i           (rx_data_i),
    .rx_valid_i          (rx_valid_i),
    .i_MC_StatCLR        (i_MC_StatCLR),
    .info_start_flag_o   (info_start_flag_o),
    .info_type_o         (info_type_o),
    .channel_mang_o      (channel_mang_o),
    .info_len_o          (info_len_o),
    .yw_data_o           (yw_data_o),
    .yw_data_valid_o     (yw_data_valid_o),
    .byte_cnt_equal_25_o (byte_cnt_equal_25_o),
    .frame_done_o        (frame_done_o),
    .frame_err_o         (frame_err_o),
    .frame_cnt_o         (frame_cnt_o),
    .err_cnt_o           (err_cnt_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 2 ns after the edge; the driver only changes inputs on negedges,
  // so rx_* and exp_* still describe the byte accepted at that edge.
  always @(posedge sys_clk_i) begin
    #2;
    if (rst_n_i) begin
      if (yw_data_valid_o || (rx_valid_i && exp_pl))
        check_val("yw_data", {yw_data_valid_o, yw_data_o}, {rx_valid_i & exp_pl, rx_data_i});
      if (info_start_flag_o || (rx_valid_i && exp_st))
        check_val("start_pulse", info_start_flag_o, rx_valid_i & exp_st);
      if (byte_cnt_equal_25_o || (rx_valid_i && exp_25))
        check_val("cnt25_pulse", byte_cnt_equal_25_o, rx_valid_i & exp_25);
      if (frame_done_o || (rx_valid_i && exp_dn))
        check_val("done_pulse", frame_done_o, rx_valid_i & exp_dn);
      if (!tmo_mode && (frame_err_o || (rx_valid_i && exp_er)))
        check_val("err_pulse", frame_err_o, rx_valid_i & exp_er);
      n_start += int'(info_start_flag_o);
      n_yw    += int'(yw_data_valid_o);
      n_25    += int'(byte_cnt_equal_25_o);
      n_done  += int'(frame_done_o);
      n_err   += int'(frame_err_o);
    end
  end

  task automatic drive(input logic [7:0] b, input logic [4:0] f);
    @(negedge sys_clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    {exp_25, exp_er, exp_dn, exp_st, exp_pl} = f;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge sys_clk_i);
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h5A;
      {exp_25, exp_er, exp_dn, exp_st, exp_pl} = '0;
    end
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [15:0] ch, input logic [15:0] len,
                            input logic [7:0] pbase, input logic [7:0] chk_delta, input bit clr_at_chk,
                            input int gap_after, input int gap_len, input int abort_at);
    logic [7:0] hdr [5];
    logic [7:0] sum, b;
    logic [4:0] f;
    logic [15:0] k;
    hdr[0] = typ; hdr[1] = ch[15:8]; hdr[2] = ch[7:0]; hdr[3] = len[15:8]; hdr[4] = len[7:0];
    drive(SYNC_H, 5'd0);
    drive(SYNC_L, F_ST);
    sum = '0;
    k   = '0;
    for (int i = 0; i < 5; i++) begin
      k = k + 16'd1;
      f = (k == CNT_IDX) ? F_25 : 5'd0;
      if (k == OFS_LEN_L && len > MAX_LEN) f = f | F_ER;
      drive(hdr[i], f);
      sum = sum + hdr[i];
    end
    if (len > MAX_LEN) return;
    for (int i = 0; i < int'(len); i++) begin
      if (i == abort_at) return;
      if (i == gap_after) gap(gap_len);
      k = k + 16'd1;
      b = pbase + i[7:0];
      drive(b, F_PL | ((k == CNT_IDX) ? F_25 : 5'd0));
      sum = sum + b;
    end
    k = k + 16'd1;
    f = ((k == CNT_IDX) ? F_25 : 5'd0) | ((chk_delta == 8'd0) ? F_DN : F_ER);
    drive(sum + chk_delta, f);
    if (clr_at_chk) i_MC_StatCLR = 8'h01;
    gap(1);
    i_MC_StatCLR = 8'h00;
  endtask

  task automatic snap();
    s_start = n_start; s_yw = n_yw; s_25 = n_25; s_done = n_done; s_err = n_err;
  endtask

  task automatic expect_counts(input string tag, input int st, input int yw, input int c25,
                               input int dn, input int er);
    gap(3);
    check_val({tag, "_start"}, n_start - s_start, st);
    check_val({tag, "_yw"},    n_yw - s_yw,       yw);
    check_val({tag, "_cnt25"}, n_25 - s_25,       c25);
    check_val({tag, "_done"},  n_done - s_done,   dn);
    check_val({tag, "_err"},   n_err - s_err,     er);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pulses"}, {info_start_flag_o, yw_data_valid_o, byte_cnt_equal_25_o,
                                 frame_done_o, frame_err_o}, 0);
    check_val({tag, "_type_yw"}, {info_type_o, yw_data_o}, 0);
    check_val({tag, "_ch_len"}, {channel_mang_o, info_len_o}, 0);
    check_val({tag, "_frame_cnt"}, frame_cnt_o, 0);
    check_val({tag, "_err_cnt"}, err_cnt_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    gap(2);

    // Good frame, checksum 0x1D
    snap();
    send_frame(8'h0B, 16'h0002, 16'h0020, 8'h00, 8'h00, 0, -1, 0, -1);
    expect_counts("good", 1, 32, 1, 1, 0);
    check_val("good_type", info_type_o, 8'h0B);
    check_val("good_ch", channel_mang_o, 16'h0002);
    check_val("good_len", info_len_o, 16'h0020);
    check_val("good_frame_cnt", frame_cnt_o, 1);
    check_val("good_err_cnt", err_cnt_o, 0);

    snap();
    send_frame(8'h0B, 16'h0002, 16'h0020, 8'h00, 8'h01, 0, -1, 0, -1);
    expect_counts("badchk", 1, 32, 1, 0, 1);
    check_val("badchk_frame_cnt", frame_cnt_o, 1);
    check_val("badchk_err_cnt", err_cnt_o, 1);

    // Sync hunt: a stray byte breaks SYNC1, a repeated SYNC_H keeps it
    snap();
    drive(8'h55, 5'd0); drive(SYNC_H, 5'd0); drive(8'h12, 5'd0); drive(SYNC_H, 5'd0);
    send_frame(8'h21, 16'h1234, 16'd10, 8'hA0, 8'h00, 0, -1, 0, -1);
    expect_counts("hunt", 1, 10, 0, 1, 0);
    check_val("hunt_type", info_type_o, 8'h21);
    check_val("hunt_ch", channel_mang_o, 16'h1234);
    check_val("hunt_frame_cnt", frame_cnt_o, 2);

    snap();
    send_frame(8'h33, 16'hBEEF, 16'h0801, 8'h00, 8'h00, 0, -1, 0, -1);
    expect_counts("lenerr", 1, 0, 0, 0, 1);
    check_val("lenerr_len", info_len_o, 16'h0801);
    check_val("lenerr_err_cnt", err_cnt_o, 2);

    snap();
    send_frame(8'h05, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, -1, 0, -1);
    expect_counts("len0", 1, 0, 0, 1, 0);
    check_val("len0_len", info_len_o, 16'h0000);
    check_val("len0_frame_cnt", frame_cnt_o, 3);

    snap();
    send_frame(8'h44, 16'h00F0, 16'd8, 8'h10, 8'h00, 0, 3, 40, -1);
    expect_counts("gap", 1, 8, 0, 1, 0);
    check_val("gap_frame_cnt", frame_cnt_o, 4);

    snap();
    send_frame(8'h7E, 16'h0101, MAX_LEN, 8'h33, 8'h00, 0, -1, 0, -1);
    expect_counts("maxlen", 1, 2048, 1, 1, 0);
    check_val("maxlen_len", info_len_o, 16'h0800);
    check_val("maxlen_frame_cnt", frame_cnt_o, 5);

    // Clear lands on the same cycle as the increment from a good CHK
    snap();
    send_frame(8'h0B, 16'h0002, 16'h0004, 8'h00, 8'h00, 1, -1, 0, -1);
    expect_counts("clr", 1, 4, 0, 1, 0);
    check_val("clr_frame_cnt", frame_cnt_o, 0);
    check_val("clr_err_cnt", err_cnt_o, 0);

    @(negedge sys_clk_i);
    force dut.u_frame_cnt.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_frame_cnt.cnt_q;
    snap();
    send_frame(8'h0B, 16'h0002, 16'h0004, 8'h00, 8'h00, 0, -1, 0, -1);
    expect_counts("sat", 1, 4, 0, 1, 0);
    check_val("sat_frame_cnt", frame_cnt_o, 32'hFFFF_FFFF);

`ifdef RX_TIMEOUT_EN
    snap();
    send_frame(8'h66, 16'h0A0A, 16'd20, 8'h40, 8'h00, 0, -1, 0, 5);
    tmo_mode = 1;
    gap(TMO_CYC + 4);
    tmo_mode = 0;
    check_val("tmo_err", n_err - s_err, 1);
    check_val("tmo_yw", n_yw - s_yw, 5);
    check_val("tmo_err_cnt", err_cnt_o, 1);
    snap();
    send_frame(8'h67, 16'h0B0B, 16'd6, 8'h50, 8'h00, 0, -1, 0, -1);
    expect_counts("after_tmo", 1, 6, 0, 1, 0);
    check_val("after_tmo_type", info_type_o, 8'h67);
`endif

    // Reset in the middle of a payload
    send_frame(8'h99, 16'h5555, 16'd12, 8'h00, 8'h00, 0, -1, 0, 4);
    @(negedge sys_clk_i);
    rst_n_i = 1'b0;
    #1;
    check_all_zero("midrst");
    gap(2);
    rst_n_i = 1'b1;
    gap(1);
    snap();
    send_frame(8'h12, 16'h3456, 16'd3, 8'hF0, 8'h00, 0, -1, 0, -1);
    expect_counts("postrst", 1, 3, 0, 1, 0);
    check_val("postrst_ch", channel_mang_o, 16'h3456);
    check_val("postrst_frame_cnt", frame_cnt_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
